// File: rtl/btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// btn_debounce_pulse
//
// Conditions a raw, asynchronous, bouncy pushbutton for the serial input of
// the Mealy sequence detector. The raw input is brought into the clk domain
// through a SYNC_STAGES-deep synchronizer. A four-state FSM with a stability
// counter then accepts a new level only after the synchronized value has been
// seen on DEBOUNCE_CYCLES+1 consecutive edges. Each accepted press yields
// exactly one btn_pulse, and each accepted release yields exactly one
// btn_release_pulse.
//
// Optional build macro: AUTO_REPEAT_EN
//   When defined, btn_pulse re-fires every REPEAT_CYCLES cycles while the
//   button stays in HELD. When undefined, REPEAT_CYCLES is only range-checked.
//
// Ports
//   clk               in   system clock, rising edge
//   reset             in   asynchronous, active-high reset
//   btn_raw           in   raw button, asynchronous to clk, may bounce
//   btn_level         out  debounced level (registered)
//   btn_pulse         out  one-cycle strobe on accepted press (registered)
//   btn_release_pulse out  one-cycle strobe on accepted release (registered)
// ---------------------------------------------------------------------------
module btn_debounce_pulse #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int CNT_W           = 18,
    parameter int REPEAT_CYCLES   = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse,
    output logic btn_release_pulse
);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    // Elaboration-time guard on the parameter ranges.
    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 || REPEAT_CYCLES < 1 ||
        longint'(DEBOUNCE_CYCLES - 1) >= (longint'(1) << CNT_W)) begin : g_bad_params
        $error("btn_debounce_pulse: illegal parameter combination");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_s;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   w_press_nxt;
    logic                   w_rel_nxt;
    logic                   w_level_nxt;
    logic                   w_pulse_nxt;
    logic                   r_level;
    logic                   r_pulse;
    logic                   r_rel;

    // Synchronizer: shift chain, the FSM only ever looks at the last stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], btn_raw};
        end
    end

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_press_nxt = 1'b0;
        w_rel_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_s) w_state_nxt = PRESS_WAIT;
            end
            PRESS_WAIT: begin
                if (!w_s) begin
                    w_state_nxt = IDLE;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = HELD;
                    w_press_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            HELD: begin
                if (!w_s) w_state_nxt = RELEASE_WAIT;
            end
            RELEASE_WAIT: begin
                if (w_s) begin
                    w_state_nxt = HELD;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = IDLE;
                    w_rel_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
        // Every state entry starts a fresh count, so the counter never wraps.
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
        // Level is 1 throughout HELD and RELEASE_WAIT; it is registered below,
        // so it flips on the same edge as the corresponding pulse.
        w_level_nxt = (w_state_nxt == HELD) || (w_state_nxt == RELEASE_WAIT);
    end

`ifdef AUTO_REPEAT_EN
    localparam int RCNT_W = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RCNT_W-1:0] RCNT_LAST = RCNT_W'(REPEAT_CYCLES - 1);

    logic [RCNT_W-1:0] r_rcnt;
    logic [RCNT_W-1:0] w_rcnt_nxt;
    logic              w_rpt;

    always_comb begin
        w_rcnt_nxt = r_rcnt;
        w_rpt      = 1'b0;
        if (r_state == HELD) begin
            if (r_rcnt == RCNT_LAST) begin
                w_rpt      = 1'b1;
                w_rcnt_nxt = '0;
            end else begin
                w_rcnt_nxt = r_rcnt + 1'b1;
            end
        end
        // Any entry into HELD (new press or rejected release glitch) restarts
        // the repeat period; RELEASE_WAIT simply holds the count.
        if (w_state_nxt == HELD && r_state != HELD) w_rcnt_nxt = '0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rcnt <= '0;
        end else begin
            r_rcnt <= w_rcnt_nxt;
        end
    end

    assign w_pulse_nxt = w_press_nxt | w_rpt;
`else
    assign w_pulse_nxt = w_press_nxt;
`endif

    // Output registers: no combinational path from btn_raw to any output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_level <= 1'b0;
            r_pulse <= 1'b0;
            r_rel   <= 1'b0;
        end else begin
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
            r_rel   <= w_rel_nxt;
        end
    end

    assign btn_level         = r_level;
    assign btn_pulse         = r_pulse;
    assign btn_release_pulse = r_rel;

endmodule

// File: tb/tb_btn_debounce_pulse.sv
// ---------------------------------------------------------------------------
// tb_btn_debounce_pulse
//
// Self-checking bench for btn_debounce_pulse with SYNC_STAGES=2,
// DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8. A behavioural model tracks the
// synchronizer delay as a sample queue and debounces by run length of samples
// that disagree with the accepted level. A compare process checks every cycle
// against that model. Directed scenarios also pin hand-computed expectations
// edge by edge. Honours AUTO_REPEAT_EN the same way as the design.
// ---------------------------------------------------------------------------
module tb_btn_debounce_pulse;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int CW   = 2;
    localparam int RPT  = 8;
    localparam int LAT  = SYNC + DEB;
`ifdef AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk     = 1'b0;
    logic reset   = 1'b1;
    logic btn_raw = 1'b0;
    logic btn_level;
    logic btn_pulse;
    logic btn_release_pulse;

    int checks = 0;
    int errors = 0;

    btn_debounce_pulse #(
        .SYNC_STAGES    (SYNC),
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW),
        .REPEAT_CYCLES  (RPT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .btn_raw          (btn_raw),
        .btn_level        (btn_level),
        .btn_pulse        (btn_pulse),
        .btn_release_pulse(btn_release_pulse)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b required=%b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic m_sync [SYNC];
    int   m_run;
    int   m_rcnt;
    logic m_lvl, m_p, m_r;

    always @(posedge clk or posedge reset) begin
        logic s;
        bit   held;
        if (reset) begin
            for (int i = 0; i < SYNC; i++) m_sync[i] = 1'b0;
            m_run  = 0;
            m_rcnt = 0;
            m_lvl  = 1'b0;
            m_p    = 1'b0;
            m_r    = 1'b0;
        end else begin
            s    = m_sync[SYNC-1];
            held = m_lvl && (m_run == 0);
            for (int i = SYNC - 1; i > 0; i--) m_sync[i] = m_sync[i-1];
            m_sync[0] = btn_raw;
            m_p = 1'b0;
            m_r = 1'b0;
            if (AR && held) begin
                if (m_rcnt == RPT - 1) begin
                    m_p    = 1'b1;
                    m_rcnt = 0;
                end else begin
                    m_rcnt++;
                end
            end
            if (s != m_lvl) begin
                m_run++;
                if (m_run == DEB + 1) begin
                    m_lvl  = s;
                    m_p    = s;
                    m_r    = !s;
                    m_run  = 0;
                    m_rcnt = 0;
                end
            end else begin
                if (m_lvl && !held) m_rcnt = 0;
                m_run = 0;
            end
        end
    end

    always @(negedge clk) begin
        chk("model_level", btn_level, m_lvl);
        chk("model_pulse", btn_pulse, m_p);
        chk("model_release", btn_release_pulse, m_r);
    end

    // ---------------- directed helpers ----------------
    function automatic logic exp_press(input int n);
        return (n == LAT) || (AR && n > LAT && ((n - LAT) % RPT) == 0);
    endfunction

    // Drive one sample at a falling edge, let one rising edge take it,
    // then check the registered outputs at the next falling edge.
    task automatic step(input logic raw, input logic el, input logic ep,
                        input logic er, input bit chk_p, input string tag);
        btn_raw = raw;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_level"}, btn_level, el);
        if (chk_p) chk({tag, "_pulse"}, btn_pulse, ep);
        chk({tag, "_release"}, btn_release_pulse, er);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_level"}, btn_level, 1'b0);
        chk({tag, "_pulse"}, btn_pulse, 1'b0);
        chk({tag, "_release"}, btn_release_pulse, 1'b0);
    endtask

    task automatic release_seq(input string tag, input bit chk_p);
        for (int n = 0; n < 10; n++)
            step(1'b0, n < LAT, 1'b0, n == LAT, chk_p, tag);
    endtask

    initial begin
        logic v;
        int   len;

        // 1: reset with button held, then detection from deassertion
        btn_raw = 1'b1;
        reset   = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("t1_in_reset");
        end
        reset = 1'b0;
        for (int n = 0; n < 10; n++)
            step(1'b1, n >= LAT, exp_press(n), 1'b0, 1'b1, "t1_press");
        release_seq("t1_release", 1'b1);

        // 2: clean press held 20 cycles
        for (int n = 0; n < 20; n++)
            step(1'b1, n >= LAT, exp_press(n), 1'b0, 1'b1, "t2_press");

        // 4: release glitch from HELD, then a real release
        for (int n = 0; n < 2; n++) step(1'b0, 1'b1, 1'b0, 1'b0, !AR, "t4_glitch");
        for (int n = 0; n < 8; n++) step(1'b1, 1'b1, 1'b0, 1'b0, !AR, "t4_glitch");
        release_seq("t4_release", !AR);

        // 3: bounce (1,1,1,0) x5 never accepted
        for (int r = 0; r < 5; r++)
            for (int k = 0; k < 4; k++)
                step(k < 3, 1'b0, 1'b0, 1'b0, 1'b1, "t3_bounce");
        for (int n = 0; n < 4; n++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, "t3_settle");

        // 5: reset in the middle of PRESS_WAIT
        for (int n = 0; n < 5; n++) step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, "t5_pre");
        reset = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check_zero("t5_in_reset");
        end
        reset = 1'b0;
        for (int n = 0; n < 10; n++)
            step(1'b1, n >= LAT, exp_press(n), 1'b0, 1'b1, "t5_press");
        release_seq("t5_release", 1'b1);

        // 6: long hold, 40 cycles (repeat pulses only with AUTO_REPEAT_EN)
        for (int n = 0; n < 40; n++)
            step(1'b1, n >= LAT, exp_press(n), 1'b0, 1'b1, "t6_hold");
        release_seq("t6_release", !AR);

        // Random runs with occasional mid-cycle asynchronous resets
        for (int k = 0; k < 400; k++) begin
            v = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) len = $urandom_range(DEB + 2, 3 * DEB + 4);
            else                           len = $urandom_range(1, DEB + 1);
            for (int j = 0; j < len; j++) begin
                btn_raw = v;
                @(negedge clk);
            end
            if ($urandom_range(0, 29) == 0) begin
                #2 reset = 1'b1;
                @(negedge clk);
                @(negedge clk);
                reset = 1'b0;
            end
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/btn_debounce_pulse.md
Name: btn_debounce_pulse

Overview:
- Front-end conditioning stage that feeds the Mealy sequence detector's serial input.
- Takes a raw, asynchronous, bouncy pushbutton/switch and synchronizes it into clk.
- Debounces it with a 4-state FSM and a stability counter.
- Emits a clean level plus single-cycle press/release pulses, so each physical press becomes exactly one detector input event.

Parameters:
SYNC_STAGES, 2, number of synchronizer flops on btn_raw (legal >=2).
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a transition (5 ms at 50 MHz; legal >=1).
CNT_W, 18, debounce counter width; must hold DEBOUNCE_CYCLES-1.
REPEAT_CYCLES, 12500000, auto-repeat period in cycles; used only with AUTO_REPEAT_EN.

Ports:
clk  input  1  system clock, rising-edge.
reset  input  1  asynchronous, active-high reset.
btn_raw  input  1  raw button, asynchronous to clk, may bounce.
btn_level  output  1  debounced button level.
btn_pulse  output  1  one-cycle strobe on accepted press (drives detector P1).
btn_release_pulse  output  1  one-cycle strobe on accepted release.

Behaviour:
- Interface: reset is asynchronous, active-high; clock is clk.
- Reset (asynchronous, any time, including mid-count):
  - synchronizer flops = 0, FSM = IDLE, counters = 0.
  - btn_level = 0, btn_pulse = 0, btn_release_pulse = 0.
- All outputs are registered; no combinational path from btn_raw.
- Synchronizer: SYNC_STAGES-deep shift chain; last stage = s. FSM consumes only s.
- IDLE:
  - level 0.
  - s=1 -> PRESS_WAIT, cnt<=0.
- PRESS_WAIT:
  - s=0 -> IDLE; bounce rejected, no output.
  - else cnt==DEBOUNCE_CYCLES-1 -> HELD; btn_pulse<=1 for exactly one cycle, btn_level<=1 same edge.
  - else cnt++.
- HELD:
  - level 1.
  - s=0 -> RELEASE_WAIT, cnt<=0.
- RELEASE_WAIT:
  - level stays 1.
  - s=1 -> HELD; glitch rejected, no pulse.
  - else cnt==DEBOUNCE_CYCLES-1 -> IDLE; btn_release_pulse<=1 one cycle, btn_level<=0 same edge.
  - else cnt++.
- Acceptance criterion: btn_raw must be sampled at the same value on DEBOUNCE_CYCLES+1 consecutive edges.
- Latency: pulse/level change appears after edge SYNC_STAGES+DEBOUNCE_CYCLES, counting the first edge that samples the new value as edge 0.
- Never both pulses in the same cycle.
- btn_pulse is never asserted in consecutive cycles without AUTO_REPEAT_EN.
- Counter never wraps: it is cleared on every state entry and bounded by DEBOUNCE_CYCLES-1.
- Button held through reset deassertion: synchronizer restarts from 0, so a fresh press is detected after full latency.

Optional Feature:
AUTO_REPEAT_EN
- Defined:
  - Repeat counter rcnt is cleared on every entry to HELD and increments each cycle in HELD.
  - When rcnt==REPEAT_CYCLES-1, btn_pulse<=1 for one cycle and rcnt<=0.
  - rcnt is held in RELEASE_WAIT and cleared by reset.
- Undefined: no rcnt logic, REPEAT_CYCLES ignored, one btn_pulse per accepted press.

Test Plan:
(SYNC_STAGES=2, DEBOUNCE_CYCLES=4, REPEAT_CYCLES=8)
1. Reset asserted with btn_raw=1 -> all outputs 0 during reset. Deassert with btn_raw held 1 -> btn_pulse high exactly one cycle after edge 6 post-deassert; btn_level 1 from edge 6.
2. Clean press, btn_raw 0->1 for 20 cycles -> single btn_pulse after edge 6; btn_level 1 from edge 6 until release; btn_release_pulse stays 0.
3. Bounce: btn_raw pattern (1,1,1,0) repeated 5 times -> btn_pulse, btn_level, btn_release_pulse all stay 0.
4. From HELD:
   - btn_raw low 2 cycles then high -> btn_level stays 1, no pulses.
   - Then btn_raw low steady -> btn_release_pulse one cycle and btn_level 0, both after edge 6.
5. Reset asserted at edge 4 of a clean press (PRESS_WAIT) -> outputs 0, no btn_pulse. After deassertion with btn_raw still 1 -> pulse after edge 6.
6. AUTO_REPEAT_EN:
   - btn_raw high 40 cycles -> btn_pulse after edges 6, 14, 22, 30, 38, then release pulse.
   - Macro undefined -> only after edge 6.
